// File: rtl/flexbex_ibex_pkg.sv
// Shared definitions for the Ibex data-side Wishbone bridge: FSM encoding,
// default bus timeout and the saturating wait-counter increment.
package flexbex_ibex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } bus_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam logic [7:0]  WAIT_MAX        = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == WAIT_MAX) begin
            return WAIT_MAX;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/flexbex_ibex_bus_timer.sv
// Saturating 8-bit bus wait counter; flags expiry in the cycle the count
// would reach LIMIT (LIMIT of 0 never expires).
module flexbex_ibex_bus_timer
    import flexbex_ibex_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT_V = 8'(LIMIT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count value when incrementing
    always_comb begin
        cnt_d = sat_inc8(cnt_q);
    end

    // Wait counter: cleared on bus entry, counts idle bus cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (clr_i) begin
            cnt_q <= 8'd0;
        end else if (inc_i) begin
            cnt_q <= cnt_d;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Expiry compare against the configured limit
    always_comb begin
        expired_o = 1'b0;
        if ((LIMIT_V != 8'd0) && inc_i && (cnt_d == LIMIT_V)) begin
            expired_o = 1'b1;
        end else begin
            expired_o = 1'b0;
        end
    end

endmodule

// File: rtl/flexbex_ibex_data_wb_bridge.sv
// Bridges the Ibex LSU data request/grant/rvalid protocol onto a single
// classic Wishbone master cycle per access, with an optional bus timeout.
module flexbex_ibex_data_wb_bridge
    import flexbex_ibex_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy_o
);

    bus_state_e  state_q;
    logic        cyc_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        busy_q;

    logic        gnt_s;
    logic        bus_ack_s;
    logic        bus_err_s;
    logic        tmr_inc_s;
    logic        tmr_exp_s;

    // Grant and bus-response qualification; responses only count inside a cycle
    always_comb begin
        gnt_s     = 1'b0;
        bus_ack_s = 1'b0;
        bus_err_s = 1'b0;
        tmr_inc_s = 1'b0;
        if (!rst && ((state_q == ST_IDLE) || (state_q == ST_RESP))) begin
            gnt_s = data_req_i;
        end else begin
            gnt_s = 1'b0;
        end
        if ((state_q == ST_BUS) && cyc_q) begin
            bus_ack_s = wbm_ack_i;
            bus_err_s = wbm_err_i;
            tmr_inc_s = ~wbm_ack_i & ~wbm_err_i;
        end else begin
            bus_ack_s = 1'b0;
            bus_err_s = 1'b0;
            tmr_inc_s = 1'b0;
        end
    end

    flexbex_ibex_bus_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_bus_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (gnt_s),
        .inc_i     (tmr_inc_s),
        .expired_o (tmr_exp_s)
    );

    // Bridge FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 32'd0;
            sel_q    <= 4'd0;
            dat_q    <= 32'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    if (gnt_s) begin
                        state_q <= ST_BUS;
                        cyc_q   <= 1'b1;
                        we_q    <= data_we_i;
                        adr_q   <= data_addr_i;
                        sel_q   <= data_be_i;
                        dat_q   <= data_wdata_i;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        cyc_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_BUS: begin
                    // Error (bus or timeout) takes priority over a coincident ack
                    if (bus_err_s || tmr_exp_s) begin
                        state_q  <= ST_RESP;
                        cyc_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= 32'd0;
                    end else if (bus_ack_s) begin
                        state_q  <= ST_RESP;
                        cyc_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b0;
                        rdata_q  <= we_q ? 32'd0 : wbm_dat_i;
                    end else begin
                        state_q  <= ST_BUS;
                        cyc_q    <= 1'b1;
                        rvalid_q <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cyc_q    <= 1'b0;
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_gnt_o    = gnt_s;
    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = we_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_dat_o     = dat_q;
    assign busy_o        = busy_q;

endmodule
